apb_req_master: RTL and testbench

- Upstream APB requester that drives the 2-slave, 20-bit address, 16-bit data APB bus consumed by the memory/peripheral slave stage.
- Accepts single transactions on a valid/ready request channel and runs each as one APB setup/access transfer.
- Waits on pready with a timeout and returns read data and error status on a valid/ready response channel.
- Used as the bus driver in block-level benches and by the crypto control path.

---
 rtl/apb_req_master_if.sv | 57 +++++
 rtl/apb_req_master.sv | 162 ++++++++++++++++
 tb/tb_apb_req_master.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// apb_req_master_if : request/response channels plus the APB bus of the requester
// Revision: 1.0
// ============================================================================
interface apb_req_master_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    localparam int STRB_W = DATA_W / 8;

    // Request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_strb;

    // Response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // APB bus
    logic [1:0]        psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        input  rsp_ready,
        input  prdata, pready, pslverr,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, paddr, pwdata, pwrite, pstrb
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        output rsp_ready,
        output prdata, pready, pslverr,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, paddr, pwdata, pwrite, pstrb
    );
endinterface
`default_nettype wire

// File: rtl/apb_req_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// apb_req_master : single-outstanding valid/ready to APB requester with timeout
// Revision: 1.0
// ============================================================================
module apb_req_master #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    apb_req_master_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e            state_q,       state_d;
    logic              req_ready_q,   req_ready_d;
    logic              rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic              rsp_err_q,     rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [1:0]        psel_q,        psel_d;
    logic              penable_q,     penable_d;
    logic [ADDR_W-1:0] paddr_q,       paddr_d;
    logic [DATA_W-1:0] pwdata_q,      pwdata_d;
    logic              pwrite_q,      pwrite_d;
    logic [STRB_W-1:0] pstrb_q,       pstrb_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [CNT_W-1:0]  w_cnt_inc;

    assign w_cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 2'b00;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            pstrb_q       <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            pstrb_q       <= pstrb_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_ready_d   = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        pstrb_d       = pstrb_q;
        cnt_d         = cnt_q;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    paddr_d     = bus.req_addr;
                    pwdata_d    = bus.req_wdata;
                    pwrite_d    = bus.req_write;
                    pstrb_d     = bus.req_write ? bus.req_strb : '0;
                    psel_d      = bus.req_addr[ADDR_W-1] ? 2'b10 : 2'b01;
                    penable_d   = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end

            ST_ACCESS: begin
                // pready is checked first so a completion on the final wait cycle wins over the abort
                if (bus.pready) begin
                    rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
                    rsp_err_d     = bus.pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 2'b00;
                    penable_d     = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == TIMEOUT_CNT) begin
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        psel_d        = 2'b00;
                        penable_d     = 1'b0;
                        state_d       = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pstrb       = pstrb_q;
endmodule
`default_nettype wire

// File: tb/tb_apb_req_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_apb_req_master : directed vector table, reset corners and random soak
// Revision: 1.0
// ============================================================================
module tb_apb_req_master;
    localparam int AW         = 20;
    localparam int DW         = 16;
    localparam int TO         = 4;
    localparam int N_SOAK     = 1000;
    localparam int SOAK_LIMIT = 40000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    apb_req_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_req_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  strb;
        int          waits;   // pready-low ACCESS cycles before pready; >= TO means stuck low
        logic        slverr;
        logic [15:0] prdata;
        int          hold;    // cycles rsp_ready stays low once the response is up
        logic [1:0]  exp_psel;
        logic [1:0]  exp_pstrb;
        logic [15:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic        to;
        int          acc;
    } exp_t;

    vec_t        vecs [9];
    logic [15:0] mmem [32];
    logic [15:0] smem [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int midx(input logic [19:0] a);
        return int'({a[19], a[3:0]});
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] s);
        logic [15:0] r;
        r = old;
        for (int b = 0; b < 2; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        for (int lim = 0; lim < 20 && bus.req_ready !== 1'b1; lim++) @(negedge clk);
        chk(name, bus.req_ready, 1);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int n;
        wait_ready($sformatf("vec%0d_req_ready", i));
        bus.req_valid = 1'b1;
        bus.req_write = v.wr;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.req_strb  = v.strb;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk($sformatf("vec%0d_setup_ready", i), bus.req_ready, 0);
        chk($sformatf("vec%0d_setup_psel", i), bus.psel, v.exp_psel);
        chk($sformatf("vec%0d_setup_penable", i), bus.penable, 0);
        chk($sformatf("vec%0d_setup_paddr", i), bus.paddr, v.addr);
        chk($sformatf("vec%0d_setup_pwrite", i), bus.pwrite, v.wr);
        chk($sformatf("vec%0d_setup_pwdata", i), bus.pwdata, v.wdata);
        chk($sformatf("vec%0d_setup_pstrb", i), bus.pstrb, v.exp_pstrb);
        // SETUP must ignore the slave entirely
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        n = (v.waits >= TO) ? TO : v.waits + 1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_acc%0d_penable", i, k), bus.penable, 1);
            chk($sformatf("vec%0d_acc%0d_psel", i, k), bus.psel, v.exp_psel);
            chk($sformatf("vec%0d_acc%0d_paddr", i, k), bus.paddr, v.addr);
            chk($sformatf("vec%0d_acc%0d_pwrite", i, k), bus.pwrite, v.wr);
            chk($sformatf("vec%0d_acc%0d_pwdata", i, k), bus.pwdata, v.wdata);
            chk($sformatf("vec%0d_acc%0d_pstrb", i, k), bus.pstrb, v.exp_pstrb);
            chk($sformatf("vec%0d_acc%0d_rsp_valid", i, k), bus.rsp_valid, 0);
            bus.pready  = (k == v.waits);
            bus.pslverr = (k == v.waits) ? v.slverr : 1'b1;
            bus.prdata  = (k == v.waits) ? v.prdata : 16'hDEAD;
        end
        @(negedge clk);
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        chk($sformatf("vec%0d_resp_psel", i), bus.psel, 0);
        chk($sformatf("vec%0d_resp_penable", i), bus.penable, 0);
        chk($sformatf("vec%0d_resp_valid", i), bus.rsp_valid, 1);
        chk($sformatf("vec%0d_resp_rdata", i), bus.rsp_rdata, v.exp_rdata);
        chk($sformatf("vec%0d_resp_err", i), bus.rsp_err, v.exp_err);
        chk($sformatf("vec%0d_resp_timeout", i), bus.rsp_timeout, v.exp_to);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_hold%0d_valid", i, h), bus.rsp_valid, 1);
            chk($sformatf("vec%0d_hold%0d_rdata", i, h), bus.rsp_rdata, v.exp_rdata);
            chk($sformatf("vec%0d_hold%0d_flags", i, h), {bus.rsp_err, bus.rsp_timeout},
                {v.exp_err, v.exp_to});
            chk($sformatf("vec%0d_hold%0d_bus", i, h), {bus.req_ready, bus.psel, bus.penable}, 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk($sformatf("vec%0d_done_valid", i), bus.rsp_valid, 0);
        chk($sformatf("vec%0d_done_req_ready", i), bus.req_ready, 1);
    endtask

    // Leaves the bench at the negedge of the first ACCESS cycle with pready low.
    task automatic start_read(input logic [19:0] a);
        wait_ready("start_req_ready");
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = a;
        bus.pready    = 1'b0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic soak();
        exp_t        q[$];
        exp_t        x;
        int          sent = 0, got = 0, cyc = 0, acc_seen = 0, cur_w = 0, w;
        logic        cur_err = 1'b0, cur_wr = 1'b0, e, prev_setup = 1'b0, accepted = 1'b0;
        logic [19:0] cur_addr = '0, a;
        logic [15:0] cur_wdata = '0;
        logic [1:0]  cur_strb = '0, o_psel;
        logic        o_pen, o_rv, o_rr;
        for (int i = 0; i < 32; i++) begin
            mmem[i] = 16'($urandom);
            smem[i] = mmem[i];
        end
        while (got < N_SOAK && cyc < SOAK_LIMIT) begin
            @(negedge clk);
            cyc++;
            o_psel = bus.psel;
            o_pen  = bus.penable;
            o_rv   = bus.rsp_valid;
            o_rr   = bus.req_ready;

            if (o_psel != 2'b00 || o_pen) begin
                chk("soak_psel_onehot", 32'($countones(o_psel)), 1);
                chk("soak_psel", o_psel, cur_addr[19] ? 2'b10 : 2'b01);
                chk("soak_paddr", bus.paddr, cur_addr);
                chk("soak_pwrite", bus.pwrite, cur_wr);
                chk("soak_pwdata", bus.pwdata, cur_wdata);
                chk("soak_pstrb", bus.pstrb, cur_wr ? cur_strb : 2'b00);
            end
            if (prev_setup) chk("soak_setup_to_access", o_pen, 1);
            prev_setup = (o_psel != 2'b00) && !o_pen;
            if (prev_setup) acc_seen = 0;

            // APB slave with a per-transfer wait count chosen at request time
            if (o_pen) begin
                if (acc_seen == cur_w) begin
                    bus.pready  = 1'b1;
                    bus.pslverr = cur_err;
                    bus.prdata  = smem[midx(bus.paddr)];
                    if (bus.pwrite && !cur_err)
                        smem[midx(bus.paddr)] = merge(smem[midx(bus.paddr)], bus.pwdata, bus.pstrb);
                end else begin
                    bus.pready  = 1'b0;
                    bus.pslverr = 1'($urandom);
                    bus.prdata  = 16'($urandom);
                end
                acc_seen++;
            end else begin
                bus.pready  = 1'($urandom);
                bus.pslverr = 1'($urandom);
                bus.prdata  = 16'($urandom);
            end

            bus.rsp_ready = ($urandom_range(0, 2) != 0);
            if (o_rv) begin
                chk("soak_resp_bus_idle", {o_psel, o_pen}, 0);
                if (q.size() == 0) begin
                    chk("soak_rsp_unexpected", q.size(), 1);
                end else begin
                    chk("soak_rsp_rdata", bus.rsp_rdata, q[0].rdata);
                    chk("soak_rsp_err", bus.rsp_err, q[0].err);
                    chk("soak_rsp_timeout", bus.rsp_timeout, q[0].to);
                    if (bus.rsp_ready) begin
                        chk("soak_access_cycles", acc_seen, q[0].acc);
                        x = q.pop_front();
                        got++;
                    end
                end
            end

            if (accepted) begin
                bus.req_valid = 1'b0;
                accepted      = 1'b0;
            end
            if (!bus.req_valid && sent < N_SOAK && $urandom_range(0, 3) != 0) begin
                a             = 20'($urandom);
                bus.req_addr  = a;
                bus.req_write = 1'($urandom);
                bus.req_wdata = 16'($urandom);
                bus.req_strb  = 2'($urandom);
                bus.req_valid = 1'b1;
            end
            if (bus.req_valid && o_rr) begin
                w         = int'($urandom_range(0, 5));
                e         = ($urandom_range(0, 3) == 0);
                cur_w     = w;
                cur_err   = e;
                cur_addr  = bus.req_addr;
                cur_wr    = bus.req_write;
                cur_wdata = bus.req_wdata;
                cur_strb  = bus.req_strb;
                if (w >= TO) begin
                    x = '{16'h0000, 1'b1, 1'b1, TO};
                end else if (cur_wr) begin
                    x = '{16'h0000, e, 1'b0, w + 1};
                    if (!e) mmem[midx(cur_addr)] = merge(mmem[midx(cur_addr)], cur_wdata, cur_strb);
                end else begin
                    x = '{mmem[midx(cur_addr)], e, 1'b0, w + 1};
                end
                q.push_back(x);
                sent++;
                accepted = 1'b1;
            end
        end
        chk("soak_all_responses", got, N_SOAK);
        chk("soak_queue_empty", q.size(), 0);
        idle_inputs();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 20'h00010, 16'h0000, 2'b11, 0,  1'b0, 16'hABCD, 0,  2'b01, 2'b00, 16'hABCD, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 20'h80004, 16'h1234, 2'b10, 3,  1'b0, 16'h5555, 0,  2'b10, 2'b10, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 20'h00020, 16'h0000, 2'b00, 2,  1'b1, 16'h0F0F, 0,  2'b01, 2'b00, 16'h0F0F, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 20'h80100, 16'h0000, 2'b00, 99, 1'b0, 16'hBEEF, 0,  2'b10, 2'b00, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 20'h00030, 16'h0000, 2'b00, 3,  1'b0, 16'h1357, 0,  2'b01, 2'b00, 16'h1357, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 20'h00040, 16'hFFFF, 2'b00, 1,  1'b0, 16'h7777, 0,  2'b01, 2'b00, 16'h0000, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 20'h7FFFF, 16'h0000, 2'b00, 0,  1'b0, 16'h2468, 10, 2'b01, 2'b00, 16'h2468, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 20'h80000, 16'hA5A5, 2'b11, 0,  1'b1, 16'h3333, 2,  2'b10, 2'b11, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 20'hFFFFF, 16'hC3C3, 2'b01, 99, 1'b0, 16'h4444, 0,  2'b10, 2'b01, 16'h0000, 1'b1, 1'b1};

        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_fields", {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, 0);
        chk("rst_psel_penable", {bus.psel, bus.penable}, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_pwdata_pwrite_pstrb", {bus.pwdata, bus.pwrite, bus.pstrb}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("rel_req_ready_low", bus.req_ready, 0);
        @(negedge clk);
        chk("rel_req_ready_high", bus.req_ready, 1);

        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("idle_rsp_ready_no_effect", {bus.rsp_valid, bus.psel, bus.penable, bus.req_ready}, 1);
        end
        bus.rsp_ready = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset asserted mid-ACCESS drops the bus without waiting for a clock edge
        start_read(20'h80008);
        chk("rstacc_pre_penable", bus.penable, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstacc_psel", bus.psel, 0);
        chk("rstacc_penable", bus.penable, 0);
        chk("rstacc_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("rstacc_rel_ready_low", bus.req_ready, 0);
        @(negedge clk);
        chk("rstacc_rel_ready_high", bus.req_ready, 1);
        chk("rstacc_rel_bus_idle", {bus.psel, bus.penable, bus.rsp_valid}, 0);

        // Reset while a response waits discards it
        start_read(20'h00044);
        bus.pready = 1'b1;
        bus.prdata = 16'h9999;
        @(negedge clk);
        bus.pready = 1'b0;
        chk("rstrsp_pre_valid", bus.rsp_valid, 1);
        chk("rstrsp_pre_rdata", bus.rsp_rdata, 16'h9999);
        #2 reset_n = 1'b0;
        #1;
        chk("rstrsp_valid", bus.rsp_valid, 0);
        chk("rstrsp_rdata", bus.rsp_rdata, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rstrsp_rel_ready_high", bus.req_ready, 1);
        chk("rstrsp_rel_valid", bus.rsp_valid, 0);

        soak();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
